// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/AES-256 encryption core with an internal
// round-key schedule and valid/ready handshakes on both sides.
// Optional build macro AES_KEY_CACHE_EN keeps the expanded schedule across
// blocks and skips key expansion when the next key matches the stored one.
module aes_iter_core #(
  parameter int unsigned KEY_LEN = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       plaintext,
  input  logic [KEY_LEN-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       ciphertext,
  output logic               busy,
  output logic               cache_hit
);

  localparam int unsigned NR     = (KEY_LEN == 256) ? 14 : 10;
  localparam int unsigned KSTEPS = (KEY_LEN == 256) ? 13 : 10;
  // Slot written by step 0 (slots below it come straight from the key)
  localparam int unsigned NK_OFF = (KEY_LEN == 256) ? 2 : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEXP  = 3'd1;
  localparam logic [2:0] S_INIT  = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  generate
    if (KEY_LEN != 128 && KEY_LEN != 256) begin : g_bad_key_len
      $error("aes_iter_core: KEY_LEN must be 128 or 256");
    end
  endgenerate

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ------------------------------------------------------------ round parts
  // Byte i of the state sits at bits [127-8i -: 8]; column-major layout.
  function automatic logic [127:0] encrypt_final_round(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c+0) -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  // ---------------------------------------------------------------- storage
  logic [2:0]   r_state;
  logic [3:0]   r_round;
  logic [3:0]   r_step;
  logic [127:0] r_data;
  logic [127:0] r_ct;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         r_busy;
  logic [127:0] r_rk [NR+1];

  logic [2:0]   w_state_nx;
  logic [3:0]   w_round_nx;
  logic [3:0]   w_step_nx;
  logic [127:0] w_data_nx;
  logic [127:0] w_ct_nx;
  logic         w_out_valid_nx;
  logic         w_accept;
  logic         w_kexp;
  logic         w_kexp_last;
  logic         w_hit;

  // --------------------------------------------------------- key expansion
  logic [127:0] w_far;
  logic [127:0] w_near;
  logic [3:0]   w_near_idx;
  logic [3:0]   w_wr_idx;
  logic [31:0]  w_last;
  logic [31:0]  w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_kexp_word;
  logic [127:0] w_sub_shift;

  assign w_near_idx  = 4'(r_step + 4'(NK_OFF - 1));
  assign w_wr_idx    = 4'(r_step + 4'(NK_OFF));
  assign w_far       = r_rk[r_step];
  assign w_near      = r_rk[w_near_idx];
  assign w_last      = w_near[31:0];
  assign w_kexp_last = (r_step == 4'(KSTEPS - 1));

  // Temp word: RotWord+SubWord+Rcon, or SubWord alone on odd AES-256 steps
  always_comb begin
    w_temp = '0;
    if (KEY_LEN == 256) begin
      if (r_step[0]) w_temp = sub_word(w_last);
      else           w_temp = sub_word({w_last[23:0], w_last[31:24]}) ^
                              {rcon(4'(r_step >> 1)), 24'h0};
    end else begin
      w_temp = sub_word({w_last[23:0], w_last[31:24]}) ^ {rcon(r_step), 24'h0};
    end
  end

  assign w_n0        = w_far[127:96] ^ w_temp;
  assign w_n1        = w_far[95:64]  ^ w_n0;
  assign w_n2        = w_far[63:32]  ^ w_n1;
  assign w_n3        = w_far[31:0]   ^ w_n2;
  assign w_kexp_word = {w_n0, w_n1, w_n2, w_n3};

  assign w_sub_shift = encrypt_final_round(r_data);

  // Next-state and next-output logic
  always_comb begin
    w_state_nx     = r_state;
    w_round_nx     = r_round;
    w_step_nx      = r_step;
    w_data_nx      = r_data;
    w_ct_nx        = r_ct;
    w_out_valid_nx = r_out_valid;
    w_accept       = 1'b0;
    w_kexp         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept   = 1'b1;
          w_data_nx  = plaintext;
          w_step_nx  = '0;
          w_round_nx = '0;
          w_state_nx = w_hit ? S_INIT : S_KEXP;
        end
      end
      S_KEXP: begin
        w_kexp    = 1'b1;
        w_step_nx = 4'(r_step + 4'd1);
        if (w_kexp_last) begin
          w_step_nx  = '0;
          w_state_nx = S_INIT;
        end
      end
      S_INIT: begin
        w_data_nx  = add_round_key(r_data, r_rk[0]);
        w_round_nx = 4'd1;
        w_state_nx = S_ROUND;
      end
      S_ROUND: begin
        w_data_nx  = add_round_key(mix_columns(w_sub_shift), r_rk[r_round]);
        w_round_nx = 4'(r_round + 4'd1);
        if (r_round == 4'(NR - 1)) w_state_nx = S_FINAL;
      end
      S_FINAL: begin
        w_ct_nx        = add_round_key(w_sub_shift, r_rk[NR]);
        w_out_valid_nx = 1'b1;
        w_state_nx     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_round     <= '0;
      r_step      <= '0;
      r_data      <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_round     <= w_round_nx;
      r_step      <= w_step_nx;
      r_data      <= w_data_nx;
      r_ct        <= w_ct_nx;
      r_out_valid <= w_out_valid_nx;
      r_in_ready  <= (w_state_nx == S_IDLE);
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  // Round-key schedule: key slots on accept, one expanded slot per KEXP step
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rk[0] <= key[KEY_LEN-1 -: 128];
      if (KEY_LEN == 256) r_rk[1] <= key[127:0];
    end
    if (w_kexp) r_rk[w_wr_idx] <= w_kexp_word;
  end

`ifdef AES_KEY_CACHE_EN
  logic [KEY_LEN-1:0] r_key;
  logic               r_cache_valid;
  logic               r_cache_hit;

  assign w_hit = r_cache_valid && (key == r_key);

  // Cache bookkeeping: invalidate on a miss, validate once expansion completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key         <= '0;
      r_cache_valid <= 1'b0;
      r_cache_hit   <= 1'b0;
    end else begin
      r_cache_hit <= w_accept && w_hit;
      if (w_accept) begin
        r_key <= key;
        if (!w_hit) r_cache_valid <= 1'b0;
      end else if (w_kexp && w_kexp_last) begin
        r_cache_valid <= 1'b1;
      end
    end
  end

  assign cache_hit = r_cache_hit;
`else
  assign w_hit     = 1'b0;
  assign cache_hit = 1'b0;
`endif

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;
  assign busy       = r_busy;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: one AES-128 and one AES-256 instance,
// FIPS-197 vectors, latency, backpressure, mid-block reset and key reuse.
module tb_aes_iter_core;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_FIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K256   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256   = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_KEY_CACHE_EN
  localparam int   REUSE_LAT = 11;
  localparam logic REUSE_HIT = 1'b1;
`else
  localparam int   REUSE_LAT = 21;
  localparam logic REUSE_HIT = 1'b0;
`endif

  logic         clk;
  logic         rst_n;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a, hit_a;
  logic [127:0] pt_a, key_a, ct_a;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, hit_b;
  logic [127:0] pt_b, ct_b;
  logic [255:0] key_b;

  int n_checks;
  int n_errors;

  aes_iter_core #(.KEY_LEN(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .plaintext(pt_a), .key(key_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .ciphertext(ct_a), .busy(busy_a), .cache_hit(hit_a)
  );

  aes_iter_core #(.KEY_LEN(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .plaintext(pt_b), .key(key_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .ciphertext(ct_b), .busy(busy_b), .cache_hit(hit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; pt_a = '0; key_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; pt_b = '0; key_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || ct_a !== 128'h0 ||
        busy_a !== 1'b0 || hit_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset128: got rdy=%b ov=%b ct=%h busy=%b hit=%b expected 1 0 0 0 0",
               in_ready_a, out_valid_a, ct_a, busy_a, hit_a);
    end
    n_checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || ct_b !== 128'h0 ||
        busy_b !== 1'b0 || hit_b !== 1'b0) begin
      n_errors++;
      $display("FAIL reset256: got rdy=%b ov=%b ct=%h busy=%b hit=%b expected 1 0 0 0 0",
               in_ready_b, out_valid_b, ct_b, busy_b, hit_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One AES-128 block: accept, scramble inputs, measure latency, optional stall
  task automatic run_128(input logic [127:0] k, input logic [127:0] pt,
                         input logic [127:0] exp_ct, input int exp_lat,
                         input logic exp_hit, input int bp_cycles, input string nm);
    int   cyc;
    logic hit_seen;
    @(negedge clk);
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_ready: got %b expected 1", nm, in_ready_a);
    end
    in_valid_a = 1'b1; key_a = k; pt_a = pt;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0; key_a = ~k; pt_a = ~pt;
    n_checks++;
    if (busy_a !== 1'b1 || in_ready_a !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_busy: got busy=%b rdy=%b expected 1 0", nm, busy_a, in_ready_a);
    end
    hit_seen = hit_a;
    cyc = 0;
    while (out_valid_a !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (hit_a === 1'b1) hit_seen = 1'b1;
    end
    n_checks++;
    if (cyc !== exp_lat) begin
      n_errors++;
      $display("FAIL %s_latency: got %0d expected %0d", nm, cyc, exp_lat);
    end
    n_checks++;
    if (ct_a !== exp_ct) begin
      n_errors++;
      $display("FAIL %s_ct: got %h expected %h", nm, ct_a, exp_ct);
    end
    n_checks++;
    if (hit_seen !== exp_hit) begin
      n_errors++;
      $display("FAIL %s_cache_hit: got %b expected %b", nm, hit_seen, exp_hit);
    end
    for (int i = 0; i < bp_cycles; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid_a !== 1'b1 || ct_a !== exp_ct || in_ready_a !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_stall%0d: got ov=%b rdy=%b ct=%h expected 1 0 %h",
                 nm, i, out_valid_a, in_ready_a, ct_a, exp_ct);
      end
    end
    @(negedge clk);
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    out_ready_a = 1'b0;
    n_checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_handshake: got ov=%b rdy=%b busy=%b expected 0 1 0",
               nm, out_valid_a, in_ready_a, busy_a);
    end
  endtask

  task automatic test_fips128;
    run_128(K_FIPS, P_FIPS, C_FIPS, 21, 1'b0, 0, "fips128");
  endtask

  task automatic test_seq_key128;
    run_128(K0, P0, C0, 21, 1'b0, 0, "seq128");
  endtask

  task automatic test_aes256;
    int cyc;
    @(negedge clk);
    in_valid_b = 1'b1; key_b = K256; pt_b = P0;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0; key_b = ~K256; pt_b = ~P0;
    cyc = 0;
    while (out_valid_b !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (cyc !== 28) begin
      n_errors++;
      $display("FAIL aes256_latency: got %0d expected 28", cyc);
    end
    n_checks++;
    if (ct_b !== C256) begin
      n_errors++;
      $display("FAIL aes256_ct: got %h expected %h", ct_b, C256);
    end
    @(negedge clk);
    out_ready_b = 1'b1;
    @(posedge clk);
    #1;
    out_ready_b = 1'b0;
    n_checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      n_errors++;
      $display("FAIL aes256_handshake: got ov=%b rdy=%b expected 0 1", out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_backpressure;
    run_128(K_FIPS, P_FIPS, C_FIPS, 21, 1'b0, 10, "bp128");
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    in_valid_a = 1'b1; key_a = K0; pt_a = P0;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    // 10 expansion steps, INIT, then well into the rounds
    repeat (14) @(posedge clk);
    #1;
    n_checks++;
    if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_inflight: got busy=%b ov=%b expected 1 0", busy_a, out_valid_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || ct_a !== 128'h0 ||
        busy_a !== 1'b0 || hit_a !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_outputs: got rdy=%b ov=%b ct=%h busy=%b hit=%b expected 1 0 0 0 0",
               in_ready_a, out_valid_a, ct_a, busy_a, hit_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid_a !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0 || in_ready_a !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_no_output: got ov_seen=%b rdy=%b expected 0 1", seen, in_ready_a);
    end
    // Reset cleared any stored schedule, so the same key expands again
    run_128(K0, P0, C0, 21, 1'b0, 0, "post_rst");
  endtask

  task automatic test_back_to_back;
    run_128(K0, P0, C0, REUSE_LAT, REUSE_HIT, 0, "reuse_key");
    run_128(K_FIPS, P_FIPS, C_FIPS, 21, 1'b0, 0, "new_key");
    run_128(K_FIPS, P0, 128'h8df4e9aac5c7573a27d8d055d6e4d64b, REUSE_LAT, REUSE_HIT, 0,
            "reuse_key2");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_fips128();
    test_seq_key128();
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
